cr_prefix_attach_ibp_seq: RTL

Prefix fetch sequencer that sits directly upstream of the prefix memory controller. It accepts one prefix request at a time and drives the controller's load-CRC-address, increment-address and prefix-valid strobes: first the PHD region, then the PFD region. It paces word fetches against a downstream credit pool, acknowledges the controller's CRC check results, and returns one status record per prefix.

---
 rtl/cr_prefix_attach_ibp_seq.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cr_prefix_attach_ibp_seq.sv
// Prefix fetch sequencer: drives PHD then PFD load/increment/valid strobes toward the prefix memory controller.
// Latency: status one cycle after accept for an illegal prefix; otherwise after both regions are fetched and checked.
// Backpressure: one request at a time (req_ready only in IDLE); word strobes are paced by a 4-bit downstream credit pool.
// Optional build macro CR_PREFIX_ATTACH_IBP_TIMEOUT_EN adds a check-wait watchdog (status code 5).
module cr_prefix_attach_ibp_seq #(
    parameter int PHD_WORDS   = 64,
    parameter int PFD_WORDS   = 128,
    parameter int MAX_PREFIX  = 63,
    parameter int CREDIT_INIT = 4
`ifdef CR_PREFIX_ATTACH_IBP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cceip_cfg,
    input  logic       req_valid,
    input  logic [5:0] req_prefix_num,
    output logic       req_ready,
    input  logic       credit_return,
    output logic       ibp_prefix_valid,
    output logic [5:0] ibp_prefix_num,
    output logic       ibp_ld_phd_crc_addr,
    output logic       ibp_ld_pfd_crc_addr,
    output logic       ibp_inc_phd_addr,
    output logic       ibp_inc_pfd_addr,
    input  logic       pmc_phd_check_valid,
    input  logic       pmc_phd_crc_error,
    input  logic       pmc_pfd_check_valid,
    input  logic       pmc_pfd_crc_error,
    output logic       pac_phd_check_valid_ack,
    output logic       pac_pfd_check_valid_ack,
    output logic       stat_valid,
    output logic [2:0] stat_code,
    output logic [5:0] stat_prefix_num,
    output logic       stat_cceip
);

    typedef enum logic [3:0] {
        S_IDLE, S_PHD_LD, S_PHD_WAIT, S_PHD_STR, S_PHD_CHK,
        S_PFD_LD, S_PFD_WAIT, S_PFD_STR, S_PFD_CHK, S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic [7:0] cnt_q, cnt_d;
    logic       phd_err_q, phd_err_d;
    logic       pfd_err_q, pfd_err_d;
    logic [5:0] prefix_q, prefix_d;
    logic       cceip_q, cceip_d;
    logic [2:0] done_code;
    logic       ack_phd_d, ack_pfd_d;
    logic       inc_phd_d, inc_pfd_d;

    logic       req_ready_q;
    logic       prefix_valid_q;
    logic       ld_phd_q, ld_pfd_q;
    logic       inc_phd_q, inc_pfd_q;
    logic       ack_phd_q, ack_pfd_q;
    logic       stat_valid_q;
    logic [2:0] stat_code_q;

`ifdef CR_PREFIX_ATTACH_IBP_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        wd_expired;
    assign wd_expired = (wd_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, counters, credit pool and latched error flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phd_err_d = phd_err_q;
        pfd_err_d = pfd_err_q;
        prefix_d  = prefix_q;
        cceip_d   = cceip_q;
        done_code = 3'd0;
        ack_phd_d = 1'b0;
        ack_pfd_d = 1'b0;

        // A strobe on the wire is a committed word: it consumes one credit.
        // A coincident return cancels it; a lone return saturates at 15.
        credit_d = credit_q;
        if (inc_phd_q || inc_pfd_q) begin
            if (!credit_return) begin
                credit_d = credit_q - 4'd1;
            end
        end else if (credit_return && (credit_q != 4'hF)) begin
            credit_d = credit_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    prefix_d  = req_prefix_num;
                    cceip_d   = cceip_cfg;
                    phd_err_d = 1'b0;
                    pfd_err_d = 1'b0;
                    cnt_d     = 8'd0;
                    if ((req_prefix_num == 6'd0) || ({1'b0, req_prefix_num} > 7'(MAX_PREFIX))) begin
                        state_d   = S_DONE;
                        done_code = 3'd4;
                    end else begin
                        state_d = S_PHD_LD;
                    end
                end
            end
            S_PHD_LD: begin
                cnt_d   = 8'd0;
                state_d = S_PHD_WAIT;
            end
            // Two cycles for the controller to capture the CRC word.
            S_PHD_WAIT: begin
                if (cnt_q == 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = S_PHD_STR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PHD_STR: begin
                if (inc_phd_q) begin
                    if (cnt_q == 8'(PHD_WORDS - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = S_PHD_CHK;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_PHD_CHK: begin
                if (pmc_phd_check_valid) begin
                    ack_phd_d = 1'b1;
                    phd_err_d = pmc_phd_crc_error;
                    state_d   = S_PFD_LD;
                end
`ifdef CR_PREFIX_ATTACH_IBP_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d   = S_DONE;
                    done_code = 3'd5;
                end
`endif
            end
            S_PFD_LD: begin
                cnt_d   = 8'd0;
                state_d = S_PFD_WAIT;
            end
            S_PFD_WAIT: begin
                if (cnt_q == 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = S_PFD_STR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PFD_STR: begin
                if (inc_pfd_q) begin
                    if (cnt_q == 8'(PFD_WORDS - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = S_PFD_CHK;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_PFD_CHK: begin
                if (pmc_pfd_check_valid) begin
                    ack_pfd_d = 1'b1;
                    pfd_err_d = pmc_pfd_crc_error;
                    state_d   = S_DONE;
                    done_code = {1'b0, pmc_pfd_crc_error, phd_err_q};
                end
`ifdef CR_PREFIX_ATTACH_IBP_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d   = S_DONE;
                    done_code = 3'd5;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are decided one cycle ahead from registered state so they
        // never depend combinationally on credit_return.
        inc_phd_d = (state_d == S_PHD_STR) && (credit_d != 4'd0);
        inc_pfd_d = (state_d == S_PFD_STR) && (credit_d != 4'd0);
    end

`ifdef CR_PREFIX_ATTACH_IBP_TIMEOUT_EN
    // Watchdog restarts on every state entry and counts only in the check states.
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = 16'd0;
        end else if ((state_q == S_PHD_CHK) || (state_q == S_PFD_CHK)) begin
            wd_d = wd_q + 16'd1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= 16'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // State, datapath and registered output strobes decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            credit_q       <= 4'(CREDIT_INIT);
            cnt_q          <= 8'd0;
            phd_err_q      <= 1'b0;
            pfd_err_q      <= 1'b0;
            prefix_q       <= 6'd0;
            cceip_q        <= 1'b0;
            req_ready_q    <= 1'b1;
            prefix_valid_q <= 1'b0;
            ld_phd_q       <= 1'b0;
            ld_pfd_q       <= 1'b0;
            inc_phd_q      <= 1'b0;
            inc_pfd_q      <= 1'b0;
            ack_phd_q      <= 1'b0;
            ack_pfd_q      <= 1'b0;
            stat_valid_q   <= 1'b0;
            stat_code_q    <= 3'd0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            cnt_q          <= cnt_d;
            phd_err_q      <= phd_err_d;
            pfd_err_q      <= pfd_err_d;
            prefix_q       <= prefix_d;
            cceip_q        <= cceip_d;
            req_ready_q    <= (state_d == S_IDLE);
            prefix_valid_q <= (state_d inside {S_PHD_LD, S_PHD_WAIT, S_PHD_STR, S_PHD_CHK,
                                               S_PFD_LD, S_PFD_WAIT, S_PFD_STR, S_PFD_CHK});
            ld_phd_q       <= (state_d == S_PHD_LD);
            ld_pfd_q       <= (state_d == S_PFD_LD);
            inc_phd_q      <= inc_phd_d;
            inc_pfd_q      <= inc_pfd_d;
            ack_phd_q      <= ack_phd_d;
            ack_pfd_q      <= ack_pfd_d;
            stat_valid_q   <= (state_d == S_DONE);
            stat_code_q    <= (state_d == S_DONE) ? done_code : 3'd0;
        end
    end

    assign req_ready               = req_ready_q;
    assign ibp_prefix_valid        = prefix_valid_q;
    assign ibp_prefix_num          = prefix_q;
    assign ibp_ld_phd_crc_addr     = ld_phd_q;
    assign ibp_ld_pfd_crc_addr     = ld_pfd_q;
    assign ibp_inc_phd_addr        = inc_phd_q;
    assign ibp_inc_pfd_addr        = inc_pfd_q;
    assign pac_phd_check_valid_ack = ack_phd_q;
    assign pac_pfd_check_valid_ack = ack_pfd_q;
    assign stat_valid              = stat_valid_q;
    assign stat_code               = stat_code_q;
    assign stat_prefix_num         = prefix_q;
    assign stat_cceip              = cceip_q;

endmodule
